// File: rtl/tpu_job_sequencer.sv
// ---------------------------------------------------------------------------
// tpu_job_sequencer
//
// Sequences one job of up to 2^FIFO_ADDRSIZE weight tiles after a start pulse:
// for each tile it loads the weights, streams num_rows input vectors from the
// unified buffer and writes the skew-corrected result rows to the results
// SRAM. A PIPE_LAT-deep shift register tracks each UB read through the array
// so that its result row is written exactly PIPE_LAT cycles later.
//
// Optional feature macro: SEQ_PERF_CNT_EN (adds the cycle_count output).
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start         job request pulse, sampled only in IDLE
//   src_base      UB address of row 0, tile 0
//   dst_base      results SRAM address of row 0, tile 0
//   num_rows      rows per tile (R)
//   num_tiles     tiles per job (T)
//   busy          high in every state except IDLE
//   done          one-cycle pulse at job end
//   ub_rd_en      UB read strobe
//   ub_addr       UB read address
//   w_addr        weight SRAM address (current tile index)
//   we_rl         weight reload strobe to the systolic array
//   res_we        results SRAM write enable
//   res_addr      results SRAM write address
//   cycle_count   busy cycles of the last job (SEQ_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module tpu_job_sequencer #(
    parameter int unsigned ADDRESSSIZE   = 10,
    parameter int unsigned FIFO_ADDRSIZE = 2,
    parameter int unsigned PIPE_LAT      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESSSIZE-1:0]   src_base,
    input  logic [ADDRESSSIZE-1:0]   dst_base,
    input  logic [ADDRESSSIZE-1:0]   num_rows,
    input  logic [FIFO_ADDRSIZE:0]   num_tiles,
    output logic                     busy,
    output logic                     done,
    output logic                     ub_rd_en,
    output logic [ADDRESSSIZE-1:0]   ub_addr,
    output logic [FIFO_ADDRSIZE-1:0] w_addr,
    output logic                     we_rl,
    output logic                     res_we,
    output logic [ADDRESSSIZE-1:0]   res_addr
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]              cycle_count
`endif
);

    localparam int unsigned AW    = ADDRESSSIZE;
    localparam int unsigned FW    = FIFO_ADDRSIZE;
    localparam int unsigned TW    = FIFO_ADDRSIZE + 1;
    // Wide enough for base + T*R + index without losing carries before truncation.
    localparam int unsigned SUM_W = ADDRESSSIZE + FIFO_ADDRSIZE + 2;
    // Phase counter covers both the FEED row index and the DRAIN countdown.
    localparam int unsigned CNT_W = (ADDRESSSIZE > ($clog2(PIPE_LAT) + 1)) ?
                                    ADDRESSSIZE : ($clog2(PIPE_LAT) + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_FEED,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     sub_q, sub_d;
    logic [TW-1:0]        t_q, t_d;
    logic [SUM_W-1:0]     off_q, off_d;
    logic [AW-1:0]        j_q, j_d;
    logic [AW-1:0]        src_q, src_d;
    logic [AW-1:0]        dst_q, dst_d;
    logic [AW-1:0]        r_q, r_d;
    logic [TW-1:0]        nt_q, nt_d;
    logic [PIPE_LAT-1:0]  pipe_q, pipe_d;

    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ub_rd_en_q, ub_rd_en_d;
    logic [AW-1:0]        ub_addr_q, ub_addr_d;
    logic [FW-1:0]        w_addr_q, w_addr_d;
    logic                 we_rl_q, we_rl_d;
    logic [AW-1:0]        res_addr_q, res_addr_d;
    logic                 res_we_q;

`ifdef SEQ_PERF_CNT_EN
    logic [15:0]          cc_q, cc_d;
`endif

    assign res_we_q = pipe_q[PIPE_LAT-1];

    // Next-state, counters and the registered-output values for the next cycle.
    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        t_d     = t_q;
        off_d   = off_q;
        j_d     = j_q;
        src_d   = src_q;
        dst_d   = dst_q;
        r_d     = r_q;
        nt_d    = nt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d = src_base;
                    dst_d = dst_base;
                    r_d   = num_rows;
                    nt_d  = num_tiles;
                    t_d   = '0;
                    off_d = '0;
                    sub_d = '0;
                    j_d   = '0;
                    state_d = ((num_rows == '0) || (num_tiles == '0)) ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (sub_q == '0) begin
                    sub_d = CNT_W'(1);
                end else begin
                    sub_d   = '0;
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                if ((sub_q + CNT_W'(1)) == CNT_W'(r_q)) begin
                    sub_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    sub_d = sub_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (sub_q == CNT_W'(PIPE_LAT - 1)) begin
                    sub_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    sub_d = sub_q + CNT_W'(1);
                end
            end
            S_NEXT: begin
                // Running t*R offset replaces a multiplier.
                t_d     = t_q + TW'(1);
                off_d   = off_q + SUM_W'(r_q);
                state_d = ((t_q + TW'(1)) == nt_q) ? S_DONE : S_LOAD_W;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Capture row counter: restarts per tile, advances after each write.
        if (state_d == S_LOAD_W) begin
            j_d = '0;
        end else if (res_we_q) begin
            j_d = j_q + AW'(1);
        end

        // Result-row tracker: each UB read emerges as a write PIPE_LAT cycles later.
        pipe_d = (pipe_q << 1) | PIPE_LAT'(ub_rd_en_q);

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        we_rl_d    = (state_d == S_LOAD_W) && (sub_d == CNT_W'(1));
        ub_rd_en_d = (state_d == S_FEED);
        ub_addr_d  = '0;
        if (state_d == S_FEED) begin
            ub_addr_d = AW'(SUM_W'(src_d) + off_d + SUM_W'(sub_d));
        end
        w_addr_d   = (state_d != S_IDLE) ? t_d[FW-1:0] : '0;
        res_addr_d = '0;
        if (state_d != S_IDLE) begin
            res_addr_d = AW'(SUM_W'(dst_d) + off_d + SUM_W'(j_d));
        end

`ifdef SEQ_PERF_CNT_EN
        // Busy-cycle counter, cleared on an accepted start, saturating.
        cc_d = cc_q;
        if ((state_q == S_IDLE) && start) begin
            cc_d = '0;
        end else if (busy_q && (cc_q != 16'hFFFF)) begin
            cc_d = cc_q + 16'd1;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sub_q      <= '0;
            t_q        <= '0;
            off_q      <= '0;
            j_q        <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            r_q        <= '0;
            nt_q       <= '0;
            pipe_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ub_rd_en_q <= 1'b0;
            ub_addr_q  <= '0;
            w_addr_q   <= '0;
            we_rl_q    <= 1'b0;
            res_addr_q <= '0;
`ifdef SEQ_PERF_CNT_EN
            cc_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            t_q        <= t_d;
            off_q      <= off_d;
            j_q        <= j_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            r_q        <= r_d;
            nt_q       <= nt_d;
            pipe_q     <= pipe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ub_rd_en_q <= ub_rd_en_d;
            ub_addr_q  <= ub_addr_d;
            w_addr_q   <= w_addr_d;
            we_rl_q    <= we_rl_d;
            res_addr_q <= res_addr_d;
`ifdef SEQ_PERF_CNT_EN
            cc_q       <= cc_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ub_rd_en = ub_rd_en_q;
    assign ub_addr  = ub_addr_q;
    assign w_addr   = w_addr_q;
    assign we_rl    = we_rl_q;
    assign res_we   = res_we_q;
    assign res_addr = res_addr_q;
`ifdef SEQ_PERF_CNT_EN
    assign cycle_count = cc_q;
`endif

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tpu_job_sequencer
//
// Bench for tpu_job_sequencer. Expected outputs for every cycle of a job are
// derived from the cycle-numbered timing rules (tile period, LOAD_W/FEED/
// capture windows) and compared against the DUT outputs sampled on the
// falling edge. cycle_count is checked when SEQ_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_tpu_job_sequencer;

    localparam int unsigned A  = 10;
    localparam int unsigned F  = 2;
    localparam int unsigned TW = F + 1;
    localparam int unsigned P  = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [A-1:0]  src_base;
    logic [A-1:0]  dst_base;
    logic [A-1:0]  num_rows;
    logic [TW-1:0] num_tiles;
    logic          busy;
    logic          done;
    logic          ub_rd_en;
    logic [A-1:0]  ub_addr;
    logic [F-1:0]  w_addr;
    logic          we_rl;
    logic          res_we;
    logic [A-1:0]  res_addr;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0]   cycle_count;
`endif

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         ub_rd_en;
        logic [A-1:0] ub_addr;
        logic [F-1:0] w_addr;
        logic         we_rl;
        logic         res_we;
        logic [A-1:0] res_addr;
    } outs_t;

    int errors = 0;
    int checks = 0;

    tpu_job_sequencer #(
        .ADDRESSSIZE   (A),
        .FIFO_ADDRSIZE (F),
        .PIPE_LAT      (P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .num_rows    (num_rows),
        .num_tiles   (num_tiles),
        .busy        (busy),
        .done        (done),
        .ub_rd_en    (ub_rd_en),
        .ub_addr     (ub_addr),
        .w_addr      (w_addr),
        .we_rl       (we_rl),
        .res_we      (res_we),
        .res_addr    (res_addr)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: outputs in cycle c of a job (cycle 0 = start sampled).
    function automatic outs_t model(input int src, input int dst, input int r,
                                    input int t, input int c);
        outs_t e;
        int per, last, k, o;
        logic empty;
        e     = '0;
        per   = r + int'(P) + 3;
        empty = (r == 0) || (t == 0);
        last  = empty ? 1 : t * per + 1;
        if (c >= 1 && c <= last) e.busy = 1'b1;
        if (c == last) e.done = 1'b1;
        if (!empty && c >= 1 && c <= last) begin
            k = (c - 1) / per;
            o = (c - 1) % per;
            e.w_addr = F'(k);
            if (c < last) begin
                e.we_rl = (o == 1);
                if (o >= 2 && o < 2 + r) begin
                    e.ub_rd_en = 1'b1;
                    e.ub_addr  = A'(src + k * r + (o - 2));
                end
                if (o >= 2 + int'(P) && o < 2 + int'(P) + r) begin
                    e.res_we   = 1'b1;
                    e.res_addr = A'(dst + k * r + (o - 2 - int'(P)));
                end
            end
        end
        return e;
    endfunction

    task automatic sample(output outs_t o);
        o.busy     = busy;
        o.done     = done;
        o.ub_rd_en = ub_rd_en;
        o.ub_addr  = ub_addr;
        o.w_addr   = w_addr;
        o.we_rl    = we_rl;
        o.res_we   = res_we;
        o.res_addr = res_addr;
    endtask

    // Runs one job from IDLE; optionally re-pulses start at cycle restart_at.
    task automatic run_job(input string name, input int src, input int dst,
                           input int r, input int t, input int restart_at);
        outs_t obs, exp;
        int last, per, nwe, ndone, done_at;
        per     = r + int'(P) + 3;
        last    = ((r == 0) || (t == 0)) ? 1 : t * per + 1;
        nwe     = 0;
        ndone   = 0;
        done_at = -1;
        @(negedge clk);
        sample(obs);
        checks++;
        if (obs !== outs_t'(0)) begin
            errors++;
            $display("FAIL %s idle before start: got %h expected 0", name, obs);
        end
        src_base  = A'(src);
        dst_base  = A'(dst);
        num_rows  = A'(r);
        num_tiles = TW'(t);
        start     = 1'b1;
        for (int c = 1; c <= last + 3; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            sample(obs);
            exp = model(src, dst, r, t, c);
            // res_addr is only meaningful while a write is due
            if (exp.busy && !exp.res_we) obs.res_addr = '0;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs, exp);
            end
            if (obs.res_we) nwe++;
            if (obs.done) begin
                ndone++;
                done_at = c;
            end
            if (c == restart_at) begin
                start     = 1'b1;
                src_base  = ~src_base;
                num_rows  = A'(r + 1);
                num_tiles = TW'(1);
            end
            if (c == restart_at + 1) start = 1'b0;
        end
        checks++;
        if (ndone != 1 || done_at != last) begin
            errors++;
            $display("FAIL %s done: got %0d pulses at cycle %0d expected 1 at cycle %0d",
                     name, ndone, done_at, last);
        end
        checks++;
        if (nwe != r * t) begin
            errors++;
            $display("FAIL %s res_we count: got %0d expected %0d", name, nwe, r * t);
        end
`ifdef SEQ_PERF_CNT_EN
        checks++;
        if (cycle_count !== 16'(last)) begin
            errors++;
            $display("FAIL %s cycle_count: got %0d expected %0d", name, cycle_count, last);
        end
`endif
    endtask

    task automatic test_reset();
        outs_t obs;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        sample(obs);
        checks++;
        if (obs !== outs_t'(0)) begin
            errors++;
            $display("FAIL reset outputs: got %h expected 0", obs);
        end
`ifdef SEQ_PERF_CNT_EN
        checks++;
        if (cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL reset cycle_count: got %0d expected 0", cycle_count);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single_tile();
        run_job("single", 0, 'h100, 4, 1, -1);
    endtask

    task automatic test_multi_tile();
        run_job("multi", 'h10, 'h200, 3, 4, -1);
    endtask

    task automatic test_wrap();
        run_job("wrap", 'h3FE, 'h3FF, 4, 1, -1);
    endtask

    task automatic test_restart_ignored();
        run_job("restart", 'h40, 'h80, 4, 2, 10);
    endtask

    task automatic test_empty();
        run_job("empty_r0", 'h55, 'h66, 0, 2, -1);
        run_job("empty_t0", 'h01, 'h02, 5, 0, -1);
    endtask

    task automatic test_reset_midjob();
        outs_t obs, exp;
        int bad;
        @(negedge clk);
        src_base  = A'(7);
        dst_base  = A'('h120);
        num_rows  = A'(4);
        num_tiles = TW'(1);
        start     = 1'b1;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            sample(obs);
            exp = model(7, 'h120, 4, 1, c);
            if (exp.busy && !exp.res_we) obs.res_addr = '0;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midrst cycle %0d: got %h expected %h", c, obs, exp);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        sample(obs);
        checks++;
        if (obs !== outs_t'(0)) begin
            errors++;
            $display("FAIL midrst async clear: got %h expected 0", obs);
        end
`ifdef SEQ_PERF_CNT_EN
        checks++;
        if (cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL midrst cycle_count: got %0d expected 0", cycle_count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            sample(obs);
            if (obs !== outs_t'(0)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst quiet after release: got %0d active cycles expected 0", bad);
        end
        run_job("after_rst", int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), -1);
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 8; n++) begin
            run_job("random", int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(1, 9)), int'($urandom_range(1, 4)), -1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        src_base  = '0;
        dst_base  = '0;
        num_rows  = '0;
        num_tiles = '0;
        test_reset();
        test_single_tile();
        test_multi_tile();
        test_wrap();
        test_restart_ignored();
        test_empty();
        test_reset_midjob();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tpu_job_sequencer.md
# tpu_job_sequencer

- Parametrised job sequencer for the TPU top level.
- Replaces the free-running 5-bit result counter and the externally driven `we_rl` / `valid_address` scheme.
- On one `start` pulse it walks a job of up to 2^FIFO_ADDRSIZE weight tiles. For each tile it:
  - loads the tile's weights from the weight SRAM into the systolic array;
  - streams `num_rows` input vectors out of the unified buffer;
  - writes each skew-corrected result row into the results SRAM at a computed address.
- It sits between the host/config port and the UB, weight SRAM, systolic array and results SRAM.

## Interface
Parameters:
- ADDRESSSIZE, 10, UB and results SRAM address width
- FIFO_ADDRSIZE, 2, weight SRAM address width; job holds up to 2^FIFO_ADDRSIZE tiles
- PIPE_LAT, 32, cycles from a UB read-address cycle to the matching result row at the reverser output; must be ≥1

Ports:
- clk  in  1  clock; one clock domain; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request pulse; sampled only in IDLE
- src_base  in  ADDRESSSIZE  UB address of row 0, tile 0
- dst_base  in  ADDRESSSIZE  results SRAM address of row 0, tile 0
- num_rows  in  ADDRESSSIZE  rows per tile (R)
- num_tiles  in  FIFO_ADDRSIZE+1  tiles per job (T)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- ub_rd_en  out  1  UB read strobe
- ub_addr  out  ADDRESSSIZE  UB read address
- w_addr  out  FIFO_ADDRSIZE  weight SRAM address = current tile index
- we_rl  out  1  weight reload strobe to the systolic array
- res_we  out  1  results SRAM write enable
- res_addr  out  ADDRESSSIZE  results SRAM write address
- cycle_count  out  16  busy-cycle count of the last job; present only with SEQ_PERF_CNT_EN

## Operation
- **start:** in IDLE, `start=1` latches `src_base`, `dst_base`, R and T.
  - If R==0 or T==0, go directly to DONE.
  - Otherwise go to LOAD_W with tile index t=0.
  - `start` outside IDLE is ignored; no queueing.
- **State sequence:**
  - IDLE
  - LOAD_W (2 cycles): cycle 1 drives `w_addr=t`; cycle 2 asserts `we_rl=1`.
  - FEED (R cycles): `ub_rd_en=1`, `ub_addr = src_base + t*R + i` for i=0..R-1.
  - DRAIN (PIPE_LAT cycles)
  - NEXT (1 cycle): t←t+1. Go to DONE if t+1==T, else go to LOAD_W.
  - DONE (1 cycle): `done=1`, then IDLE.
- **Capture path:**
  - A PIPE_LAT-deep shift register carries `ub_rd_en`.
  - Its output drives `res_we`.
  - A capture counter j, cleared in LOAD_W, gives `res_addr = dst_base + t*R + j`. j increments after each `res_we` cycle.
- **Arithmetic:**
  - All address sums are computed at full product width, then truncated to ADDRESSSIZE bits. Wrap-around modulo 2^ADDRESSSIZE is legal and silent.
  - t*R is held in a running-offset register incremented by R in NEXT; no multiplier.
- **Outputs:**
  - `w_addr` holds t in all non-IDLE states.
  - In IDLE all strobes are 0 and address outputs are 0.

## Timing
- Reset: all outputs 0 and state IDLE, asynchronously on `rst`. The capture shift register, counters, t and `cycle_count` are cleared.
- Reset mid-job aborts the job. No `done` is issued, and no `res_we` emerges after release.
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled. For tile 0:
  - LOAD_W occupies cycles 1–2 (`we_rl` in cycle 2).
  - FEED occupies cycles 3..R+2.
  - DRAIN occupies cycles R+3..R+PIPE_LAT+2.
  - NEXT is cycle R+PIPE_LAT+3.
- `res_we` is high in cycles 3+PIPE_LAT..R+PIPE_LAT+2. The last write always lands in the last DRAIN cycle.
- Per-tile period: R+PIPE_LAT+3 cycles.
- `done` is high in cycle T·(R+PIPE_LAT+3)+1, then `busy` falls.
- An empty job (R==0 or T==0) gives `done` in cycle 1 with no strobes.
- Tiles never overlap: no `ub_rd_en` for tile t+1 while `res_we` for tile t is pending.
- `start` arriving in the same cycle that DONE returns to IDLE is not sampled. It is sampled from the first IDLE cycle.

## Configuration
- Macro: **SEQ_PERF_CNT_EN**.
- Defined:
  - `cycle_count` is cleared in the `start`-sampling cycle and increments each cycle `busy=1`, saturating at 16'hFFFF.
  - It holds its value in IDLE until the next accepted `start`.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- Reset, then R=4, T=1, src_base=0, dst_base=0x100, PIPE_LAT=32 -> required response:
  - `we_rl` in cycle 2;
  - `ub_addr` 0,1,2,3 in cycles 3–6;
  - `res_we` cycles 35–38 at 0x100–0x103;
  - `done` in cycle 40;
  - `cycle_count`=40.
- R=3, T=4, src_base=0x10 -> required response:
  - `w_addr` steps 0,1,2,3;
  - tile 2 reads 0x16–0x18;
  - exactly 12 `res_we` pulses;
  - `done` at cycle 4·38+1=153.
- src_base=0x3FE, dst_base=0x3FF, R=4, T=1 -> required response:
  - `ub_addr` 0x3FE,0x3FF,0x000,0x001;
  - `res_addr` 0x3FF,0x000,0x001,0x002.
- `start` pulsed again in cycle 10 of a running job -> required response: ignored; single `done`; `cycle_count` unchanged by the second pulse.
- `rst` asserted in cycle 20 with `res_we` pending -> required response: all outputs 0 immediately; no `res_we` or `done` after release; next job runs normally.
- R=0, T=2 -> required response: `done` in cycle 1; no `we_rl`, `ub_rd_en` or `res_we`.
